// File: rtl/ddr2_fetch_pkg.sv
// Shared definitions for the DDR2 line fetcher: FSM encoding, test pattern, address packing.
// Latency: n/a (definitions only).
// Backpressure: n/a.

`ifndef DDR2_PACK_ADDR
`define DDR2_PACK_ADDR(row, col, bank) {row, col, bank}
`endif

package ddr2_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPACE = 2'd1,
        REQ   = 2'd2,
        XFR   = 2'd3
    } fetch_state_t;

    // Word pattern written into the frame buffer by the memory self-test.
    localparam logic [31:0] TEST_PATTERN = 32'hFDCB8610;

endpackage

// File: rtl/ddr2_line_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the pixel stream.
// Latency: a word pushed into an empty FIFO is on dout 1 cycle later.
// Backpressure: pop when empty is ignored; push when full is dropped (caller flags it).

module ddr2_line_fifo #(
    parameter int DATA_W  = 32,
    parameter int FIFO_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [DATA_W-1:0]  din,
    input  logic               pop,
    output logic [DATA_W-1:0]  dout,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] rd_ptr_nxt;
    logic               push_ok;
    logic               pop_ok;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign push_ok    = push & ~full;
    assign pop_ok     = pop & ~empty;
    assign rd_ptr_nxt = rd_ptr + FIFO_AW'(pop_ok);

    // Storage array: write port only, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Registered head word; bypass the array when the next head is being written now.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
            dout <= din;
        end else begin
            dout <= mem[rd_ptr_nxt];
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + FIFO_AW'(push_ok);
            rd_ptr <= rd_ptr_nxt;
            count  <= count + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/ddr2_line_fetch.sv
// Fetches frame-buffer rows from ddr2_mgr into a FIFO and streams them out as pixels.
// Latency: rd_data word appears on pix_data 1 cycle after rd_data_valid (FIFO empty).
// Backpressure: a line is requested only when the FIFO has room for all of it; pix_ready stalls the stream.
// Optional: define DDR2_FETCH_CHECK_EN to compare every stored word against the test pattern (data_fault).

module ddr2_line_fetch
    import ddr2_fetch_pkg::*;
#(
    parameter int ROW_W   = 13,
    parameter int COL_W   = 10,
    parameter int BANK_W  = 2,
    parameter int DATA_W  = 32,
    parameter int XFR_LEN = 512,
    parameter int MAX_ROW = 767,
    parameter int FIFO_AW = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    output logic                          rd_mem_req,
    output logic [ROW_W+COL_W+BANK_W-1:0] rd_mem_addr,
    output logic [9:0]                    rd_xfr_len,
    input  logic                          rd_mem_grant,
    input  logic [DATA_W-1:0]             rd_data,
    input  logic                          rd_data_valid,
    output logic [DATA_W-1:0]             pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          frame_start,
    output logic [15:0]                   frame_cnt,
    output logic                          err,
`ifdef DDR2_FETCH_CHECK_EN
    output logic                          data_fault,
`endif
    output logic                          busy
);

    localparam logic [FIFO_AW:0]  DEPTH_C    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]  LINE_WORDS = (FIFO_AW+1)'(XFR_LEN);
    localparam logic [9:0]        LAST_WORD  = 10'(XFR_LEN - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(MAX_ROW);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [ROW_W-1:0]   row_q;
    logic [9:0]         wcnt_q;
    logic [FIFO_AW:0]   free_q;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               push_ok;
    logic               pop_ok;
    logic               grant_hit;
    logic               line_done;
    logic               issue;

    assign fifo_push  = (state_q == XFR) && rd_data_valid;
    assign push_ok    = fifo_push && !fifo_full;
    assign pop_ok     = pix_ready && !fifo_empty;
    assign grant_hit  = (state_q == REQ) && rd_mem_grant;
    assign line_done  = fifo_push && (wcnt_q == LAST_WORD);
    assign issue      = (state_q == SPACE) && (state_d == REQ);

    assign rd_mem_req = (state_q == REQ);
    assign busy       = (state_q != IDLE);
    assign pix_valid  = !fifo_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: wait for a line of space, request, then collect the burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SPACE;
            SPACE:   if (stop) state_d = IDLE;
                     else if (free_q >= LINE_WORDS) state_d = REQ;
            REQ:     if (rd_mem_grant) state_d = XFR;
            XFR:     if (line_done) state_d = stop ? IDLE : SPACE;
            default: state_d = IDLE;
        endcase
    end

    // Row walk, word count, request registers, frame tracking and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            wcnt_q      <= '0;
            free_q      <= DEPTH_C;
            rd_mem_addr <= '0;
            rd_xfr_len  <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            err         <= 1'b0;
        end else begin
            // free tracks the FIFO count as it will be after this edge, so it is never stale.
            free_q      <= DEPTH_C - fifo_count - (FIFO_AW+1)'(push_ok) + (FIFO_AW+1)'(pop_ok);
            frame_start <= grant_hit && (row_q == '0);
            if (issue) begin
                rd_mem_addr <= `DDR2_PACK_ADDR(row_q, {COL_W{1'b0}}, {BANK_W{1'b0}});
                rd_xfr_len  <= 10'(XFR_LEN);
            end
            if (grant_hit) begin
                wcnt_q <= '0;
            end else if (fifo_push) begin
                wcnt_q <= wcnt_q + 10'd1;
            end
            if (line_done) begin
                if (row_q == LAST_ROW) begin
                    row_q     <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    row_q <= row_q + ROW_W'(1);
                end
            end
            if ((rd_data_valid && (state_q != XFR)) || (fifo_push && fifo_full)) begin
                err <= 1'b1;
            end
        end
    end

`ifdef DDR2_FETCH_CHECK_EN
    // Sticky pattern mismatch on any word that is stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_fault <= 1'b0;
        end else if (push_ok && (rd_data != DATA_W'(TEST_PATTERN))) begin
            data_fault <= 1'b1;
        end
    end
`endif

    ddr2_line_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (rd_data),
        .pop   (pix_ready),
        .dout  (pix_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ddr2_line_fetch.sv
// Bench for ddr2_line_fetch: acts as ddr2_mgr read side and as the pixel consumer.
// The frame is shortened to 4 rows so that a row wrap fits in a short run.
// Expected addresses, frame counts and pixel order come from a line-count model and a word queue.

module tb_ddr2_line_fetch;

    localparam int TB_MAX_ROW = 3;
    localparam int XFR       = 512;
    localparam int ROW_SHIFT = 12;
    localparam logic [31:0] PAT = 32'hFDCB8610;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        rd_mem_req;
    logic [24:0] rd_mem_addr;
    logic [9:0]  rd_xfr_len;
    logic        rd_mem_grant;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_start;
    logic [15:0] frame_cnt;
    logic        err;
    logic        busy;
`ifdef DDR2_FETCH_CHECK_EN
    logic        data_fault;
`endif

    int checks = 0;
    int errors = 0;
    int exp_line = 0;          // lines completed since the last reset
    logic [31:0] exp_q [$];    // words stored but not yet popped, oldest first
    int cons_mode = 0;         // 0 hold, 1 always ready, 2 random, 3 pop budget
    int cons_budget = 0;

    typedef struct {
        int gdelay;
        bit gaps;
        int exp_row;
        int exp_fcnt;
        bit exp_fs;
    } line_vec_t;

    line_vec_t tbl [5];

    ddr2_line_fetch #(.MAX_ROW(TB_MAX_ROW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .rd_mem_req    (rd_mem_req),
        .rd_mem_addr   (rd_mem_addr),
        .rd_xfr_len    (rd_xfr_len),
        .rd_mem_grant  (rd_mem_grant),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .frame_start   (frame_start),
        .frame_cnt     (frame_cnt),
        .err           (err),
`ifdef DDR2_FETCH_CHECK_EN
        .data_fault    (data_fault),
`endif
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(rd_mem_req), 0);
        check({tag, "_addr"}, 32'(rd_mem_addr), 0);
        check({tag, "_len"}, 32'(rd_xfr_len), 0);
        check({tag, "_pix_data"}, pix_data, 0);
        check({tag, "_pix_valid"}, 32'(pix_valid), 0);
        check({tag, "_frame_start"}, 32'(frame_start), 0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
`ifdef DDR2_FETCH_CHECK_EN
        check({tag, "_data_fault"}, 32'(data_fault), 0);
`endif
    endtask

    // Pixel consumer: decides ready for the next edge, then checks the word that edge pops.
    always @(negedge clk) begin
        bit r;
        case (cons_mode)
            1:       r = 1'b1;
            2:       r = ($urandom_range(0, 1) == 1);
            3:       r = (cons_budget > 0);
            default: r = 1'b0;
        endcase
        pix_ready = r;
        if (pix_valid && r) begin
            if (exp_q.size() == 0) begin
                check("pix_unexpected", pix_data, 32'hDEADBEEF);
            end else begin
                check("pix_data", pix_data, exp_q.pop_front());
            end
            if (cons_mode == 3) cons_budget--;
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check("drain_words_left", exp_q.size(), 0);
        @(negedge clk);
        check("drain_pix_valid", 32'(pix_valid), 0);
    endtask

    // Serve one line as ddr2_mgr: grant after gdelay cycles, then XFR words.
    // dmode: 0 counting 0..511, 1 random, 2 test pattern (word corrupt_at inverted).
    task automatic serve_line(input int gdelay, input bit gaps, input int dmode,
                              input int stop_at, input int corrupt_at,
                              output int act_row, output bit act_fs);
        int n = 0;
        int i = 0;
        int row;
        bit first = 1'b1;
        bit corrupt_sent = 1'b0;
        logic [24:0] a0;
        logic [31:0] w;
        act_row = -1;
        act_fs  = 1'b0;
        row = exp_line % (TB_MAX_ROW + 1);
        while (!rd_mem_req && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(rd_mem_req), 1);
        if (!rd_mem_req) return;
        a0 = rd_mem_addr;
        check("addr", 32'(a0), 32'(row << ROW_SHIFT));
        check("xfr_len", 32'(rd_xfr_len), 32'h200);
        repeat (gdelay) begin
            @(negedge clk);
            check("req_held", 32'(rd_mem_req), 1);
            check("addr_stable", 32'(rd_mem_addr), 32'(a0));
        end
        rd_mem_grant = 1'b1;
        @(negedge clk);
        rd_mem_grant = 1'b0;
        check("req_drop", 32'(rd_mem_req), 0);
        act_fs  = frame_start;
        act_row = int'(a0 >> ROW_SHIFT);
        check("frame_start", 32'(act_fs), 32'(row == 0));
        while (i < XFR) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                rd_data_valid = 1'b0;
            end else begin
                case (dmode)
                    0:       w = 32'(i);
                    1:       w = $urandom;
                    default: w = (i == corrupt_at) ? ~PAT : PAT;
                endcase
                if (i == stop_at) stop = 1'b1;
`ifdef DDR2_FETCH_CHECK_EN
                if (i == corrupt_at) begin
                    check("data_fault_before", 32'(data_fault), 0);
                    corrupt_sent = 1'b1;
                end
`endif
                rd_data       = w;
                rd_data_valid = 1'b1;
                exp_q.push_back(w);
                i++;
            end
            @(negedge clk);
            if (first) begin
                check("frame_start_pulse", 32'(frame_start), 0);
                first = 1'b0;
            end
`ifdef DDR2_FETCH_CHECK_EN
            if (corrupt_sent) begin
                check("data_fault_after", 32'(data_fault), 1);
                corrupt_sent = 1'b0;
            end
`endif
        end
        rd_data_valid = 1'b0;
        exp_line++;
        check("frame_cnt", 32'(frame_cnt), 32'((exp_line / (TB_MAX_ROW + 1)) % 65536));
    endtask

    initial begin
        int r_row;
        bit r_fs;
        int n;

        tbl[0] = '{0, 1'b0, 1, 0, 1'b0};
        tbl[1] = '{3, 1'b1, 2, 0, 1'b0};
        tbl[2] = '{1, 1'b0, 3, 1, 1'b0};
        tbl[3] = '{5, 1'b1, 0, 1, 1'b1};
        tbl[4] = '{0, 1'b1, 1, 1, 1'b0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; rd_mem_grant = 1'b0;
        rd_data = '0; rd_data_valid = 1'b0; pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // First line: counting data, grant two cycles after request.
        cons_mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        serve_line(2, 1'b0, 0, -1, -1, r_row, r_fs);
        check("line0_row", r_row, 0);
        check("line0_err", 32'(err), 0);
        wait_drain();

        // Table of lines through the row wrap; start mid-run must not restart at row 0.
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            serve_line(tbl[k].gdelay, tbl[k].gaps, 1, -1, -1, r_row, r_fs);
            check("tbl_row", r_row, tbl[k].exp_row);
            check("tbl_fs", 32'(r_fs), 32'(tbl[k].exp_fs));
            check("tbl_fcnt", 32'(frame_cnt), tbl[k].exp_fcnt);
        end
        wait_drain();

        // Backpressure: two lines fill the FIFO; the next waits for 512 pops.
        cons_budget = 0;
        cons_mode = 3;
        serve_line(1, 1'b0, 1, -1, -1, r_row, r_fs);
        serve_line(0, 1'b0, 1, -1, -1, r_row, r_fs);
        repeat (30) @(negedge clk);
        check("full_no_req", 32'(rd_mem_req), 0);
        check("full_pix_valid", 32'(pix_valid), 1);
        cons_budget = 511;
        n = 0;
        while (cons_budget > 0 && n < 3000) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        check("pop511_no_req", 32'(rd_mem_req), 0);
        cons_budget = 1;
        n = 0;
        while (!rd_mem_req && n < 12) begin @(negedge clk); n++; end
        check("pop512_req", 32'(rd_mem_req), 1);
        cons_mode = 1;
        serve_line(2, 1'b0, 1, -1, -1, r_row, r_fs);
        check("bp_err", 32'(err), 0);
        wait_drain();

        // Randomized lines with a random consumer.
        cons_mode = 2;
        for (int k = 0; k < 6; k++) begin
            serve_line($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1, -1, -1, r_row, r_fs);
        end
        cons_mode = 1;
        wait_drain();
        check("rand_err", 32'(err), 0);

        // stop mid-line: line completes, then the block parks.
        serve_line(1, 1'b1, 1, 100, -1, r_row, r_fs);
        check("stop_busy", 32'(busy), 0);
        repeat (20) @(negedge clk);
        check("stop_no_req", 32'(rd_mem_req), 0);
        check("stop_still_idle", 32'(busy), 0);
        stop = 1'b0;
        wait_drain();

        // Stray data while idle.
        rd_data = 32'h1234_5678;
        rd_data_valid = 1'b1;
        @(negedge clk);
        rd_data_valid = 1'b0;
        check("stray_err", 32'(err), 1);
        check("stray_no_store", 32'(pix_valid), 0);
        repeat (5) @(negedge clk);
        check("stray_err_sticky", 32'(err), 1);

        // Reset in the middle of a burst.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_line = 0;
        check("rst_err_clear", 32'(err), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!rd_mem_req && n < 20) begin @(negedge clk); n++; end
        check("rst_req", 32'(rd_mem_req), 1);
        rd_mem_grant = 1'b1;
        @(negedge clk);
        rd_mem_grant = 1'b0;
        for (int k = 0; k < 50; k++) begin
            rd_data = $urandom;
            rd_data_valid = 1'b1;
            exp_q.push_back(rd_data);
            @(negedge clk);
        end
        cons_mode = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_data_valid = 1'b0;
        exp_q.delete();
        check_all_zero("rst_mid");

        // Restart after reset at row 0.
        cons_mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef DDR2_FETCH_CHECK_EN
        serve_line(0, 1'b1, 2, -1, -1, r_row, r_fs);
        check("pattern_clean", 32'(data_fault), 0);
        serve_line(1, 1'b0, 2, -1, 100, r_row, r_fs);
        check("pattern_sticky", 32'(data_fault), 1);
`else
        serve_line(0, 1'b1, 1, -1, -1, r_row, r_fs);
        check("restart_row", r_row, 0);
`endif
        wait_drain();
        check("final_err", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
